wishbone_nn_array: RTL and testbench

//  Parametrised Wishbone-slave neural layer: NEURONS parallel neurons, each computing bias + sum(x[i]*w[n][i]) over INPUTS.

---
 rtl/wishbone_nn_array.sv | 172 +++++++++++++++++
 tb/tb_wishbone_nn_array.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_nn_array.sv
// Wishbone-slave neural layer: NEURONS parallel MAC neurons with run FSM and done interrupt.
// Optional ReLU activation is selected with the NN_RELU_EN macro.
module wishbone_nn_array #(
  parameter int unsigned NEURONS = 4,
  parameter int unsigned INPUTS  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ACC_W   = 24
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        irq_o
);

  localparam int unsigned W_DEPTH = NEURONS * INPUTS;
  localparam int unsigned X_AW    = (INPUTS > 1) ? $clog2(INPUTS) : 1;
  localparam int unsigned W_AW    = (W_DEPTH > 1) ? $clog2(W_DEPTH) : 1;
  localparam int unsigned N_AW    = (NEURONS > 1) ? $clog2(NEURONS) : 1;
  localparam int unsigned P_W     = 2 * DATA_W;
`ifdef NN_RELU_EN
  localparam logic RELU_EN = 1'b1;
`else
  localparam logic RELU_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, MAC, ACT} state_t;

  state_t                    state;
  logic [X_AW-1:0]           k_q;
  logic                      start_q;
  logic                      irq_en;
  logic                      done;
  logic signed [DATA_W-1:0]  x_mem   [INPUTS];
  logic signed [DATA_W-1:0]  w_mem   [W_DEPTH];
  logic signed [DATA_W-1:0]  bias    [NEURONS];
  logic signed [ACC_W-1:0]   acc     [NEURONS];
  logic signed [ACC_W-1:0]   result  [NEURONS];
  logic signed [P_W-1:0]     prod_c  [NEURONS];

  logic [1:0]      region_c;
  logic [9:0]      word_c;
  logic            req_c, wr_c, busy_c;
  logic            x_hit_c, w_hit_c, n_hit_c;
  logic [X_AW-1:0] x_idx_c;
  logic [W_AW-1:0] w_idx_c;
  logic [N_AW-1:0] n_idx_c;
  logic [31:0]     rd_c;
  logic            unused_c;

  assign region_c = wbs_adr_i[13:12];
  assign word_c   = wbs_adr_i[11:2];
  assign req_c    = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  assign wr_c     = req_c & wbs_we_i;
  assign busy_c   = (state != IDLE);
  assign x_hit_c  = 32'(word_c) < INPUTS;
  assign w_hit_c  = 32'(word_c) < W_DEPTH;
  assign n_hit_c  = 32'(word_c) < NEURONS;
  assign x_idx_c  = X_AW'(word_c);
  assign w_idx_c  = W_AW'(word_c);
  assign n_idx_c  = N_AW'(word_c);
  assign unused_c = ^{wbs_adr_i[31:14], wbs_adr_i[1:0]};

  // Byte-lane write merge into a DATA_W-wide field.
  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                               input logic [31:0] d,
                                               input logic [3:0] sel);
    logic [31:0] m;
    m = 32'(old);
    for (int b = 0; b < 4; b++)
      if (sel[b]) m[8*b +: 8] = d[8*b +: 8];
    return m[DATA_W-1:0];
  endfunction

  function automatic logic signed [ACC_W-1:0] act(input logic signed [ACC_W-1:0] a);
`ifdef NN_RELU_EN
    return a[ACC_W-1] ? '0 : a;
`else
    return a;
`endif
  endfunction

  // One product per neuron for the current input index.
  always_comb begin
    for (int n = 0; n < NEURONS; n++)
      prod_c[n] = P_W'(x_mem[k_q]) * P_W'(w_mem[W_AW'(n * INPUTS) + W_AW'(k_q)]);
  end

  always_comb begin
    rd_c = '0;
    case (region_c)
      2'd0: begin
        if (word_c == 10'd0)      rd_c = {30'd0, irq_en, 1'b0};
        else if (word_c == 10'd1) rd_c = {29'd0, RELU_EN, done, busy_c};
      end
      2'd1:    if (x_hit_c) rd_c = 32'(x_mem[x_idx_c]);
      2'd2:    if (w_hit_c) rd_c = 32'(w_mem[w_idx_c]);
      default: if (n_hit_c) rd_c = 32'(result[n_idx_c]);
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state     <= IDLE;
      k_q       <= '0;
      start_q   <= 1'b0;
      irq_en    <= 1'b0;
      done      <= 1'b0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      irq_o     <= 1'b0;
      for (int i = 0; i < INPUTS; i++)  x_mem[i] <= '0;
      for (int i = 0; i < W_DEPTH; i++) w_mem[i] <= '0;
      for (int n = 0; n < NEURONS; n++) begin
        bias[n]   <= '0;
        acc[n]    <= '0;
        result[n] <= '0;
      end
    end else begin
      wbs_ack_o <= req_c;
      if (req_c) wbs_dat_o <= wbs_we_i ? 32'd0 : rd_c;
      irq_o <= done & irq_en;

      // Bus writes; array contents are frozen while a run is in progress.
      if (wr_c) begin
        case (region_c)
          2'd0: begin
            if (word_c == 10'd0 && wbs_sel_i[0]) begin
              irq_en <= wbs_dat_i[1];
              if (wbs_dat_i[0] && !busy_c) start_q <= 1'b1;
            end
            if (word_c == 10'd1 && wbs_sel_i[0] && wbs_dat_i[1]) done <= 1'b0;
          end
          2'd1:    if (!busy_c && x_hit_c) x_mem[x_idx_c] <= merge(x_mem[x_idx_c], wbs_dat_i, wbs_sel_i);
          2'd2:    if (!busy_c && w_hit_c) w_mem[w_idx_c] <= merge(w_mem[w_idx_c], wbs_dat_i, wbs_sel_i);
          default: if (!busy_c && n_hit_c) bias[n_idx_c]  <= merge(bias[n_idx_c], wbs_dat_i, wbs_sel_i);
        endcase
      end

      // Run FSM; placed after the W1C so a completing run keeps DONE set.
      case (state)
        IDLE: begin
          if (start_q) begin
            start_q <= 1'b0;
            done    <= 1'b0;
            k_q     <= '0;
            state   <= MAC;
            for (int n = 0; n < NEURONS; n++) acc[n] <= ACC_W'(bias[n]);
          end
        end
        MAC: begin
          for (int n = 0; n < NEURONS; n++) acc[n] <= acc[n] + ACC_W'(prod_c[n]);
          k_q <= k_q + 1'b1;
          if (k_q == X_AW'(INPUTS - 1)) state <= ACT;
        end
        ACT: begin
          for (int n = 0; n < NEURONS; n++) result[n] <= act(acc[n]);
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_nn_array.sv
// Directed self-checking bench for wishbone_nn_array: default instance plus a narrow-accumulator
// instance (ACC_W=16) for wrap-around checks.
module tb_wishbone_nn_array;

`ifdef NN_RELU_EN
  localparam logic RELU = 1'b1;
`else
  localparam logic RELU = 1'b0;
`endif
  localparam logic [31:0] ST_IDLE = {29'd0, RELU, 2'b00};
  localparam logic [31:0] ST_DONE = {29'd0, RELU, 2'b10};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb0 = 1'b0, stb1 = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, dat = '0;
  logic        ack0, ack1, irq0, irq1;
  logic [31:0] dat0, dat1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wishbone_nn_array #(.NEURONS(4), .INPUTS(8), .DATA_W(8), .ACC_W(24)) dut0 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_stb_i(stb0), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack0), .wbs_dat_o(dat0),
    .irq_o(irq0));

  wishbone_nn_array #(.NEURONS(4), .INPUTS(8), .DATA_W(8), .ACC_W(16)) dut1 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_stb_i(stb1), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack1), .wbs_dat_o(dat1),
    .irq_o(irq1));

  function automatic logic [31:0] wa(input int region, input int word);
    return {18'd0, 2'(region), 10'(word), 2'b00};
  endfunction

  task automatic wb_acc(input bit d, input bit wen, input logic [31:0] a, input logic [31:0] v,
                        input logic [3:0] s, output logic [31:0] r);
    bit got;
    got = 1'b0;
    r   = '0;
    @(negedge clk);
    adr = a; dat = v; we = wen; sel = s; cyc = 1'b1; stb0 = !d; stb1 = d;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if ((d ? ack1 : ack0) === 1'b1) begin
        got = 1'b1;
        r   = d ? dat1 : dat0;
        break;
      end
    end
    stb0 = 1'b0; stb1 = 1'b0; cyc = 1'b0; we = 1'b0;
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL ack_timeout adr=%h", a);
    end
  endtask

  task automatic wb_wr(input bit d, input logic [31:0] a, input logic [31:0] v);
    logic [31:0] r;
    wb_acc(d, 1'b1, a, v, 4'hF, r);
  endtask

  task automatic wb_rd(input bit d, input logic [31:0] a, output logic [31:0] r);
    wb_acc(d, 1'b0, a, 32'd0, 4'hF, r);
  endtask

  task automatic wait_done(input bit d);
    logic [31:0] r;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      wb_rd(d, wa(0, 1), r);
      seen = r[1];
    end
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout dut=%0d", d);
    end
  endtask

  task automatic test_reset;
    logic [31:0] r;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({ack0, irq0, dat0} !== 34'd0) begin
      n_fail++; $display("FAIL reset_outputs got=%h exp=0", {ack0, irq0, dat0});
    end
    @(negedge clk) rst_n = 1'b1;
    wb_rd(0, wa(0, 1), r);
    n_checks++;
    if (r !== ST_IDLE) begin n_fail++; $display("FAIL reset_status got=%h exp=%h", r, ST_IDLE); end
  endtask

  task automatic test_basic;
    logic [31:0] r;
    int cnt;
    for (int i = 0; i < 8; i++) begin
      wb_wr(0, wa(1, i), 32'd1);
      wb_wr(0, wa(2, i), 32'(i + 1));
    end
    wb_wr(0, wa(3, 0), 32'd0);
    wb_wr(0, wa(0, 0), 32'd1);
    cnt = 0;
    while (dut0.done !== 1'b1 && cnt < 30) begin
      @(posedge clk); #1; cnt++;
    end
    n_checks++;
    if (cnt != 10) begin n_fail++; $display("FAIL done_latency got=%0d exp=10", cnt); end
    wb_rd(0, wa(3, 0), r);
    n_checks++;
    if (r !== 32'd36) begin n_fail++; $display("FAIL basic_result0 got=%h exp=%h", r, 32'd36); end
    wb_rd(0, wa(3, 1), r);
    n_checks++;
    if (r !== 32'd0) begin n_fail++; $display("FAIL basic_result1 got=%h exp=0", r); end
    wb_rd(0, wa(2, 3), r);
    n_checks++;
    if (r !== 32'd4) begin n_fail++; $display("FAIL weight_readback got=%h exp=4", r); end
    wb_rd(0, wa(0, 1), r);
    n_checks++;
    if (r !== ST_DONE) begin n_fail++; $display("FAIL status_done got=%h exp=%h", r, ST_DONE); end
  endtask

  task automatic test_negative;
    logic [31:0] r, e0, e1;
    for (int i = 0; i < 8; i++) begin
      wb_wr(0, wa(1, i), 32'hFFFF_FFFE);
      wb_wr(0, wa(2, 8 + i), 32'd3);
    end
    wb_wr(0, wa(3, 1), 32'd5);
    wb_wr(0, wa(0, 0), 32'd1);
    wait_done(0);
    e0 = RELU ? 32'd0 : 32'hFFFF_FFB8;
    e1 = RELU ? 32'd0 : 32'hFFFF_FFD5;
    wb_rd(0, wa(3, 0), r);
    n_checks++;
    if (r !== e0) begin n_fail++; $display("FAIL neg_result0 got=%h exp=%h", r, e0); end
    wb_rd(0, wa(3, 1), r);
    n_checks++;
    if (r !== e1) begin n_fail++; $display("FAIL neg_result1 got=%h exp=%h", r, e1); end
    wb_rd(0, wa(1, 2), r);
    n_checks++;
    if (r !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL input_sext got=%h exp=fffffffe", r); end
  endtask

  task automatic test_wrap;
    logic [31:0] r, e1;
    for (int i = 0; i < 8; i++) begin
      wb_wr(1, wa(1, i), 32'h80);
      wb_wr(1, wa(2, i), 32'h80);
      wb_wr(1, wa(2, 8 + i), 32'h80);
      wb_wr(1, wa(2, 16 + i), 32'h7F);
    end
    wb_wr(1, wa(3, 1), 32'hFF);
    wb_wr(1, wa(0, 0), 32'd1);
    wait_done(1);
    wb_rd(1, wa(3, 0), r);
    n_checks++;
    if (r !== 32'd0) begin n_fail++; $display("FAIL wrap_zero got=%h exp=0", r); end
    e1 = RELU ? 32'd0 : 32'hFFFF_FFFF;
    wb_rd(1, wa(3, 1), r);
    n_checks++;
    if (r !== e1) begin n_fail++; $display("FAIL wrap_minus1 got=%h exp=%h", r, e1); end
    wb_rd(1, wa(3, 2), r);
    n_checks++;
    if (r !== 32'h400) begin n_fail++; $display("FAIL wrap_pos got=%h exp=400", r); end
  endtask

  task automatic test_busy;
    logic [31:0] r;
    for (int i = 0; i < 8; i++) wb_wr(0, wa(1, i), 32'd1);
    wb_wr(0, wa(0, 0), 32'd1);
    wb_wr(0, wa(2, 0), 32'd7);
    wb_wr(0, wa(3, 0), 32'd100);
    wb_wr(0, wa(0, 0), 32'd1);
    wait_done(0);
    wb_rd(0, wa(2, 0), r);
    n_checks++;
    if (r !== 32'd1) begin n_fail++; $display("FAIL busy_weight got=%h exp=1", r); end
    wb_rd(0, wa(3, 0), r);
    n_checks++;
    if (r !== 32'd36) begin n_fail++; $display("FAIL busy_result0 got=%h exp=%h", r, 32'd36); end
    wb_rd(0, wa(3, 1), r);
    n_checks++;
    if (r !== 32'd29) begin n_fail++; $display("FAIL busy_result1 got=%h exp=%h", r, 32'd29); end
    wb_wr(0, wa(0, 1), 32'd2);
    repeat (20) @(posedge clk);
    wb_rd(0, wa(0, 1), r);
    n_checks++;
    if (r !== ST_IDLE) begin n_fail++; $display("FAIL single_run got=%h exp=%h", r, ST_IDLE); end
  endtask

  task automatic test_irq;
    logic [31:0] r;
    wb_wr(0, wa(0, 0), 32'd2);
    wb_rd(0, wa(0, 0), r);
    n_checks++;
    if (r !== 32'd2) begin n_fail++; $display("FAIL ctrl_irq_en got=%h exp=2", r); end
    n_checks++;
    if (irq0 !== 1'b0) begin n_fail++; $display("FAIL irq_idle got=%b exp=0", irq0); end
    wb_wr(0, wa(0, 0), 32'd3);
    wait_done(0);
    @(posedge clk); #1;
    n_checks++;
    if (irq0 !== 1'b1) begin n_fail++; $display("FAIL irq_set got=%b exp=1", irq0); end
    wb_rd(0, wa(0, 0), r);
    n_checks++;
    if (r !== 32'd2) begin n_fail++; $display("FAIL start_selfclear got=%h exp=2", r); end
    wb_wr(0, wa(0, 1), 32'd2);
    @(posedge clk); #1;
    n_checks++;
    if (irq0 !== 1'b0) begin n_fail++; $display("FAIL irq_clear got=%b exp=0", irq0); end
  endtask

  task automatic test_unmapped;
    logic [31:0] r;
    wb_wr(0, wa(1, 9), 32'h55);
    wb_rd(0, wa(1, 9), r);
    n_checks++;
    if (r !== 32'd0) begin n_fail++; $display("FAIL input_oor got=%h exp=0", r); end
    wb_rd(0, wa(0, 5), r);
    n_checks++;
    if (r !== 32'd0) begin n_fail++; $display("FAIL csr_unmapped got=%h exp=0", r); end
    wb_rd(0, wa(2, 32), r);
    n_checks++;
    if (r !== 32'd0) begin n_fail++; $display("FAIL weight_oor got=%h exp=0", r); end
    wb_rd(0, wa(3, 4), r);
    n_checks++;
    if (r !== 32'd0) begin n_fail++; $display("FAIL result_oor got=%h exp=0", r); end
    wb_acc(0, 1'b1, wa(1, 0), 32'h0000_7F7F, 4'b1110, r);
    wb_rd(0, wa(1, 0), r);
    n_checks++;
    if (r !== 32'd1) begin n_fail++; $display("FAIL lane_masked got=%h exp=1", r); end
    wb_acc(0, 1'b1, wa(1, 0), 32'hAAAA_AA80, 4'b0001, r);
    wb_rd(0, wa(1, 0), r);
    n_checks++;
    if (r !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lane0_write got=%h exp=ffffff80", r); end
  endtask

  task automatic test_reset_midrun;
    logic [31:0] r;
    wb_wr(0, wa(0, 0), 32'd3);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ack0, irq0} !== 2'b00) begin n_fail++; $display("FAIL midrun_reset_out got=%b exp=00", {ack0, irq0}); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    wb_rd(0, wa(0, 1), r);
    n_checks++;
    if (r !== ST_IDLE) begin n_fail++; $display("FAIL midrun_status got=%h exp=%h", r, ST_IDLE); end
    wb_rd(0, wa(0, 0), r);
    n_checks++;
    if (r !== 32'd0) begin n_fail++; $display("FAIL midrun_ctrl got=%h exp=0", r); end
    for (int n = 0; n < 4; n++) begin
      wb_rd(0, wa(3, n), r);
      n_checks++;
      if (r !== 32'd0) begin n_fail++; $display("FAIL midrun_result%0d got=%h exp=0", n, r); end
    end
    for (int i = 0; i < 32; i++) begin
      wb_rd(0, wa(2, i), r);
      n_checks++;
      if (r !== 32'd0) begin n_fail++; $display("FAIL midrun_weight%0d got=%h exp=0", i, r); end
    end
    repeat (15) @(posedge clk);
    wb_rd(0, wa(0, 1), r);
    n_checks++;
    if (r !== ST_IDLE) begin n_fail++; $display("FAIL midrun_aborted got=%h exp=%h", r, ST_IDLE); end
    n_checks++;
    if (irq0 !== 1'b0) begin n_fail++; $display("FAIL midrun_irq got=%b exp=0", irq0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_wrap();
    test_busy();
    test_irq();
    test_unmapped();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
